// File: rtl/rx_packet_parser.sv
// Framed-packet parser behind the UART receiver: 0xAA, LEN, payload, CHK.
// Validated payloads are buffered locally, then streamed out on valid/ready.
module rx_packet_parser #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 86800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       pkt_ok,
    output logic [7:0] pkt_len,
    output logic       err,
    output logic [1:0] err_code
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GET_LEN = 3'd1;
    localparam logic [2:0] S_GET_PAY = 3'd2;
    localparam logic [2:0] S_GET_CHK = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [1:0] E_BADLEN  = 2'd0;
    localparam logic [1:0] E_BADCHK  = 2'd1;
    localparam logic [1:0] E_TIMEOUT = 2'd2;
    localparam logic [1:0] E_OVERRUN = 2'd3;

    localparam logic [7:0] SOF = 8'hAA;
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    wr_ptr_q, wr_ptr_d;
    logic [7:0]    rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pkt_ok_q, pkt_ok_d;
    logic [7:0]    pkt_len_q, pkt_len_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    buf_q [MAX_LEN];
    logic          buf_we;
    logic          is_last;
    logic          in_frame;

    assign is_last  = (rd_ptr_q == len_q - 8'd1);
    assign in_frame = (state_q == S_GET_LEN) || (state_q == S_GET_PAY) || (state_q == S_GET_CHK);

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = (state_q == S_DRAIN) ? buf_q[rd_ptr_q[AW-1:0]] : '0;
    assign out_last  = (state_q == S_DRAIN) && is_last;
    assign pkt_ok    = pkt_ok_q;
    assign pkt_len   = pkt_len_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tcnt_d     = '0;
        pkt_ok_d   = 1'b0;
        pkt_len_d  = pkt_len_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        buf_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (byte_valid && byte_data == SOF) state_d = S_GET_LEN;
            end
            S_GET_LEN: begin
                if (byte_valid) begin
                    if (byte_data == 8'd0 || byte_data > 8'(MAX_LEN)) begin
                        err_d      = 1'b1;
                        err_code_d = E_BADLEN;
                        state_d    = S_IDLE;
                    end else begin
                        len_d    = byte_data;
                        sum_d    = byte_data;
                        wr_ptr_d = '0;
                        state_d  = S_GET_PAY;
                    end
                end
            end
            S_GET_PAY: begin
                if (byte_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 8'd1;
                    sum_d    = sum_q + byte_data;
                    if (wr_ptr_q == len_q - 8'd1) state_d = S_GET_CHK;
                end
            end
            S_GET_CHK: begin
                if (byte_valid) begin
                    if (byte_data == sum_q) begin
                        pkt_ok_d  = 1'b1;
                        pkt_len_d = len_q;
                        rd_ptr_d  = '0;
                        state_d   = S_DRAIN;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = E_BADCHK;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // Incoming bytes cannot be buffered while draining; report and keep streaming.
                if (byte_valid) begin
                    err_d      = 1'b1;
                    err_code_d = E_OVERRUN;
                end
                if (out_ready) begin
                    if (is_last) begin
                        rd_ptr_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte in the expiry cycle clears the count, so it beats the timeout.
        if (in_frame && !byte_valid) begin
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                err_d      = 1'b1;
                err_code_d = E_TIMEOUT;
                state_d    = S_IDLE;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tcnt_q     <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_len_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            for (int unsigned i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tcnt_q     <= tcnt_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_len_q  <= pkt_len_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            if (buf_we) buf_q[wr_ptr_q[AW-1:0]] <= byte_data;
        end
    end

endmodule
